mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9: byte-address width toward data memory.
REQ-002 SHALL have parameter DATA_W, default 32: data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  MEM-stage access request.
REQ-006 SHALL have port req_ready  output  1  request accepted on the rising edge where req_valid=1 and req_ready=1.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_funct3  input  3  instruction bits 14:12.
REQ-009 SHALL have port req_addr  input  DM_ADDRESS  byte address (ALU result LSBs).
REQ-010 SHALL have port req_wdata  input  DATA_W  store data (rs2).
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  DATA_W  aligned, extended load data.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal access; valid with resp_valid.
REQ-014 SHALL have port mem_addr  output  DM_ADDRESS  word address, bits [1:0] forced to 0.
REQ-015 SHALL have port mem_rd  output  1  word read strobe; mem_rdata is valid on the following cycle.
REQ-016 SHALL have port mem_wr  output  1  full-word write strobe.
REQ-017 SHALL have port mem_wdata  output  DATA_W  merged write word.
REQ-018 SHALL have port mem_rdata  input  DATA_W  word read from memory.

Function
REQ-019 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL latch we, funct3, addr and wdata at acceptance and use only the latched copies afterwards.
REQ-021 Legal loads SHALL be funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores SHALL be 000 SB, 001 SH, 010 SW.
REQ-022 Accesses SHALL be flagged illegal for any other funct3, a halfword with addr[0]=1, or a word with addr[1:0]!=00.
REQ-023 Illegal accesses SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, with no mem_rd or mem_wr.
REQ-024 Legal loads and SB/SH SHALL sequence IDLE->RD->CAP; SW SHALL go IDLE->WR directly.
REQ-025 RD SHALL assert mem_rd=1 with mem_addr={addr[DM_ADDRESS-1:2],2'b00}.
REQ-026 In CAP a load SHALL register the formatted result and go to RESP; a store SHALL register the merge and go to WR.
REQ-027 Load format: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-028 Store merge: SB replaces the byte at lane addr[1:0] with wdata[7:0]; SH replaces the half at lane addr[1] with wdata[15:0]; all other bytes keep their mem_rdata value.
REQ-029 WR SHALL assert mem_wr=1 for exactly one cycle with the merged word (SW: wdata unchanged), then go to RESP.
REQ-030 RESP SHALL assert resp_valid=1 for exactly one cycle with resp_err=0, then return to IDLE; no backpressure applies.
REQ-031 mem_rd and mem_wr SHALL never be high in the same cycle and SHALL be 0 outside RD and WR respectively.
REQ-032 Latency from the acceptance edge to resp_valid SHALL be: LW/LB/LH/LBU/LHU 3 cycles; SB/SH 4; SW 2; illegal 1.
REQ-033 req_valid while not IDLE SHALL be ignored; the pipeline holds the request until req_ready.
REQ-034 resp_rdata SHALL hold its last value until the next load completes; a store response SHALL drive resp_rdata=0.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE, req_ready=1, and all other outputs and latched registers to 0.
REQ-036 Reset mid-operation SHALL abort the access; no mem_wr or resp_valid from it may occur after reset_n rises.

Verification
REQ-037 mem word@0x10=0x8899AABB; LB addr 0x13 -> mem_rd at cycle 1, resp_valid at cycle 3, resp_rdata=0xFFFFFF88, resp_err=0.
REQ-038 Same word; LHU addr 0x12 -> resp_rdata=0x00008899; LH addr 0x10 -> 0xFFFFAABB.
REQ-039 Same word; SB addr 0x11, wdata=0x123456CC -> one mem_wr at cycle 3 with mem_wdata=0x8899CCBB, resp_valid at cycle 4.
REQ-040 SW addr 0x20, wdata=0xDEADBEEF -> no mem_rd, mem_wr at cycle 1, resp_valid at cycle 2.
REQ-041 LW addr 0x22 and funct3=011 load -> resp_valid at cycle 1 with resp_err=1, no memory strobes.
REQ-042 SH in flight, reset_n=0 during CAP -> outputs zero immediately, req_ready=1, no mem_wr ever issued for it.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer with lane formatting and read-modify-write merge
module mem_access_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_illegal;
    logic [4:0]            sh;
    logic [15:0]           lane;
    logic [DATA_W-1:0]     ld_fmt;
    logic [DATA_W-1:0]     st_mask;
    logic [DATA_W-1:0]     st_ins;
    logic [DATA_W-1:0]     st_merge;

    // wdata_q carries the store data until CAP, then the merged word that WR writes out
    assign req_ready  = state_q == IDLE;
    assign mem_rd     = state_q == RD;
    assign mem_wr     = state_q == WR;
    assign mem_addr   = (mem_rd || mem_wr) ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;
    assign mem_wdata  = mem_wr ? wdata_q : '0;
    assign resp_valid = state_q == RESP;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = rdata_q;

    // classify the incoming request: unsupported funct3 or misaligned halfword/word
    always_comb begin
        req_illegal = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                             : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110);
        req_illegal = req_illegal
                    || (req_funct3[1:0] == 2'b01 && req_addr[0])
                    || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    end

    // lane extraction for loads and lane insertion for partial stores, using the latched request
    always_comb begin
        sh       = {addr_q[1:0], 3'b000};
        lane     = 16'(mem_rdata >> sh);
        ld_fmt   = f3_q[1] ? mem_rdata
                 : f3_q[0] ? {{(DATA_W-16){~f3_q[2] & lane[15]}}, lane}
                 :           {{(DATA_W-8){~f3_q[2] & lane[7]}}, lane[7:0]};
        st_mask  = (f3_q[0] ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF)) << sh;
        st_ins   = (f3_q[0] ? DATA_W'(wdata_q[15:0]) : DATA_W'(wdata_q[7:0])) << sh;
        st_merge = (mem_rdata & ~st_mask) | st_ins;
    end

    // next-state and register updates for the access sequence
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = req_illegal;
                rdata_d = req_illegal ? '0 : rdata_q;
                state_d = req_illegal ? RESP : (req_we && req_funct3 == 3'b010) ? WR : RD;
            end
            RD: state_d = CAP;
            CAP: begin
                wdata_d = we_q ? st_merge : wdata_q;
                rdata_d = we_q ? rdata_q : ld_fmt;
                state_d = we_q ? WR : RESP;
            end
            WR: begin
                rdata_d = '0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and latched request registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule
